fib_seq_monitor: RTL and testbench

- Downstream consumer of the Fibonacci generator's per-cycle outputs: index i, current term c, next term n, all 11-bit.
- Checks every accepted sample against the previous one for index continuity, term continuity and the Fibonacci sum rule, using 11-bit wrap-around arithmetic.
- Failing samples are queued in a small FIFO with a valid/ready handshake toward a logger or scoreboard.
- Also maintains saturating sample and error counters plus a sticky overflow flag.

---
 rtl/fib_mon_pkg.sv | 25 ++
 rtl/fib_err_fifo.sv | 66 ++++++
 rtl/fib_seq_monitor.sv | 141 ++++++++++++++
 tb/tb_fib_seq_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_mon_pkg.sv
// fib_mon_pkg: shared definitions for the Fibonacci sequence monitor.
//   W            default data width of the generator index and terms
//   ERR_*        bit positions inside the 3-bit error code
//   state_e      monitor FSM states
//   err_entry_t  layout of one error-FIFO entry {err_code, i}
package fib_mon_pkg;

  localparam int unsigned W          = 11;
  localparam int unsigned ERR_CODE_W = 3;

  localparam int unsigned ERR_IDX  = 0;  // index did not advance by one
  localparam int unsigned ERR_CONT = 1;  // current term != previous next term
  localparam int unsigned ERR_SUM  = 2;  // next term != current + previous current

  typedef enum logic {
    SYNC,
    CHECK
  } state_e;

  typedef struct packed {
    logic [ERR_CODE_W-1:0] err_code;
    logic [W-1:0]          idx;
  } err_entry_t;

endpackage

// File: rtl/fib_err_fifo.sv
// fib_err_fifo: small synchronous FIFO holding failing-sample records.
//   clk      rising-edge clock
//   rst      synchronous active-low reset, empties the FIFO
//   push_i   write data_i (accepted when not full, or when popping this cycle)
//   data_i   entry to write
//   pop_i    remove the head (ignored when empty)
//   data_o   head entry, forced to zero while empty
//   full_o   all DEPTH entries occupied
//   empty_o  no entries
module fib_err_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fib_seq_monitor.sv
// fib_seq_monitor: checks the per-cycle output of a Fibonacci generator.
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   in_valid    i/c/n qualify this cycle; always accepted
//   i, c, n     generator index, current term, next term
//   out_valid   error FIFO head valid
//   out_ready   consumer takes the head
//   out_data    {err_code[2:0], i} of a failing sample
//   sample_cnt  accepted samples, saturating
//   err_cnt     failing samples (including dropped ones), saturating
//   overflow    sticky: an error record was dropped on a full FIFO
//   synced      monitor is in CHECK state
module fib_seq_monitor
  import fib_mon_pkg::*;
#(
  parameter int unsigned W     = fib_mon_pkg::W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          i,
  input  logic [W-1:0]          c,
  input  logic [W-1:0]          n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ERR_CODE_W+W-1:0] out_data,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [ERR_W-1:0]      err_cnt,
  output logic                  overflow,
  output logic                  synced
);

  localparam int unsigned EW = ERR_CODE_W + W;

  state_e state_q, state_d;

  logic [W-1:0]     prev_i_q, prev_i_d;
  logic [W-1:0]     prev_c_q, prev_c_d;
  logic [W-1:0]     prev_n_q, prev_n_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             overflow_q, overflow_d;

  logic [W-1:0]            idx_exp;
  logic [W-1:0]            sum_exp;
  logic [ERR_CODE_W-1:0]   err_code;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [EW-1:0]           fifo_head;

  // Both expectations wrap modulo 2^W; the carry is intentionally lost.
  assign idx_exp = prev_i_q + W'(1);
  assign sum_exp = c + prev_c_q;

  assign pop = !fifo_empty && out_ready;

  always_comb begin
    state_d      = state_q;
    prev_i_d     = prev_i_q;
    prev_c_d     = prev_c_q;
    prev_n_d     = prev_n_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    overflow_d   = overflow_q;
    err_code     = '0;

    if (in_valid) begin
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      prev_i_d = i;
      prev_c_d = c;
      prev_n_d = n;

      unique case (state_q)
        SYNC: state_d = CHECK;
        CHECK: begin
          // Index 0 marks a generator restart: reload history, no check.
          if (i != '0) begin
            err_code[ERR_IDX]  = (i != idx_exp);
            err_code[ERR_CONT] = (c != prev_n_q);
            err_code[ERR_SUM]  = (n != sum_exp);
          end
        end
        default: state_d = SYNC;
      endcase
    end

    push = (err_code != '0);

    if (push) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= SYNC;
      prev_i_q     <= '0;
      prev_c_q     <= '0;
      prev_n_q     <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_i_q     <= prev_i_d;
      prev_c_q     <= prev_c_d;
      prev_n_q     <= prev_n_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  fib_err_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_err_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({err_code, i}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_head;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign overflow   = overflow_q;
  assign synced     = (state_q == CHECK);

endmodule

// File: tb/tb_fib_seq_monitor.sv
module tb_fib_seq_monitor;

  localparam int W     = 11;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int ERR_W = 8;
  localparam int MOD   = 2048;
  localparam int SCNT_MAX = 65535;
  localparam int ECNT_MAX = 255;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [W-1:0]      i, c, n;
  logic              out_valid;
  logic              out_ready;
  logic [W+2:0]      out_data;
  logic [CNT_W-1:0]  sample_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              overflow;
  logic              synced;

  fib_seq_monitor #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .i          (i),
    .c          (c),
    .n          (n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .overflow   (overflow),
    .synced     (synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_prev_i, m_prev_c, m_prev_n;
  bit          m_synced;
  int          m_scnt, m_ecnt;
  bit          m_ovf;
  logic [13:0] m_q[$];

  task automatic model_edge(input bit r, input bit v, input int ii, input int cc,
                            input int nn, input bit rdy);
    int code;
    if (!r) begin
      m_prev_i = 0; m_prev_c = 0; m_prev_n = 0;
      m_synced = 0; m_scnt = 0; m_ecnt = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (v) begin
        if (m_scnt < SCNT_MAX) m_scnt++;
        if (!m_synced) m_synced = 1;
        else if (ii != 0) begin
          code = 0;
          if (ii != (m_prev_i + 1) % MOD) code |= 1;
          if (cc != m_prev_n)              code |= 2;
          if (nn != (cc + m_prev_c) % MOD) code |= 4;
          if (code != 0) begin
            if (m_ecnt < ECNT_MAX) m_ecnt++;
            if (m_q.size() < DEPTH) m_q.push_back({code[2:0], ii[10:0]});
            else m_ovf = 1;
          end
        end
        m_prev_i = ii; m_prev_c = cc; m_prev_n = nn;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic cycle(input bit r, input bit v, input int ii, input int cc,
                       input int nn, input bit rdy);
    @(negedge clk);
    rst = r; in_valid = v; i = ii[10:0]; c = cc[10:0]; n = nn[10:0]; out_ready = rdy;
    model_edge(r, v, ii, cc, nn, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Feed Fibonacci samples with indices 0..last
  task automatic feed_fib(input int last);
    int fc, fn, t;
    fc = 0; fn = 1;
    for (int k = 0; k <= last; k++) begin
      cycle(1, 1, k, fc, fn, 0);
      t = (fc + fn) % MOD; fc = fn; fn = t;
    end
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (sample_cnt !== '0) begin failures++; $display("FAIL reset_sample_cnt got=%0d exp=0", sample_cnt); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (synced !== 1'b0) begin failures++; $display("FAIL reset_synced got=%0b exp=0", synced); end
  endtask

  task automatic test_clean_run();
    int tab_i[6] = '{0, 1, 2, 3, 4, 5};
    int tab_c[6] = '{0, 1, 1, 2, 3, 5};
    int tab_n[6] = '{1, 1, 2, 3, 5, 8};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1, 1, tab_i[k], tab_c[k], tab_n[k], 0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_out_valid step=%0d got=%0b exp=0", k, out_valid); end
      checks++; if (synced !== 1'b1) begin failures++; $display("FAIL clean_synced step=%0d got=%0b exp=1", k, synced); end
    end
    checks++; if (sample_cnt !== 16'd6) begin failures++; $display("FAIL clean_sample_cnt got=%0d exp=6", sample_cnt); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_sum_error();
    do_reset();
    feed_fib(2);
    cycle(1, 1, 3, 2, 4, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sum_out_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data !== {3'b100, 11'd3}) begin failures++; $display("FAIL sum_out_data got=%0h exp=%0h", out_data, {3'b100, 11'd3}); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL sum_err_cnt got=%0d exp=1", err_cnt); end
    cycle(1, 0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sum_pop_out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    feed_fib(16);
    cycle(1, 1, 17, 1597, 536, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_out_valid got=%0b exp=0", out_valid); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL wrap_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (sample_cnt !== 16'd18) begin failures++; $display("FAIL wrap_sample_cnt got=%0d exp=18", sample_cnt); end
  endtask

  task automatic test_overflow();
    logic [13:0] exp;
    int pops;
    do_reset();
    feed_fib(1);
    // c never matches the previous next term
    for (int k = 0; k < 5; k++) cycle(1, 1, k + 2, 7 + 2 * k, 8 + 2 * k, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_out_valid got=%0b exp=1", out_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (err_cnt !== 8'd5) begin failures++; $display("FAIL ovf_err_cnt got=%0d exp=5", err_cnt); end
    checks++; if (out_data[10:0] !== 11'd2) begin failures++; $display("FAIL ovf_head_idx got=%0d exp=2", out_data[10:0]); end
    // Full FIFO: pop and push in the same cycle
    cycle(1, 1, 7, 500, 0, 1);
    checks++; if (err_cnt !== 8'd6) begin failures++; $display("FAIL ovf_pp_err_cnt got=%0d exp=6", err_cnt); end
    checks++; if (out_data[10:0] !== 11'd3) begin failures++; $display("FAIL ovf_pp_head_idx got=%0d exp=3", out_data[10:0]); end
    pops = 0;
    for (int k = 0; k < 10 && out_valid === 1'b1; k++) begin
      exp = (m_q.size() > 0) ? m_q[0] : '0;
      checks++; if (out_data !== exp) begin failures++; $display("FAIL ovf_drain_data k=%0d got=%0h exp=%0h", k, out_data, exp); end
      cycle(1, 0, 0, 0, 0, 1);
      pops++;
    end
    checks++; if (pops !== 4) begin failures++; $display("FAIL ovf_occupancy got=%0d exp=4", pops); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_restart_gaps();
    int scnt_before;
    do_reset();
    feed_fib(9);
    cycle(1, 1, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL restart_out_valid got=%0b exp=0", out_valid); end
    checks++; if (synced !== 1'b1) begin failures++; $display("FAIL restart_synced got=%0b exp=1", synced); end
    cycle(1, 1, 1, 1, 1, 0);
    scnt_before = sample_cnt;
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, $urandom_range(3, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047), 0);
      checks++; if (sample_cnt !== 16'(scnt_before)) begin failures++; $display("FAIL gap_sample_cnt k=%0d got=%0d exp=%0d", k, sample_cnt, scnt_before); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_out_valid k=%0d got=%0b exp=0", k, out_valid); end
    end
    cycle(1, 1, 2, 1, 2, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_resume_out_valid got=%0b exp=0", out_valid); end
    checks++; if (sample_cnt !== 16'd13) begin failures++; $display("FAIL gap_sample_cnt_end got=%0d exp=13", sample_cnt); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL gap_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    feed_fib(1);
    cycle(1, 1, 5, 1, 2, 0);
    cycle(1, 1, 9, 900, 3, 0);
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL mrst_out_data got=%0h exp=0", out_data); end
    checks++; if (sample_cnt !== '0) begin failures++; $display("FAIL mrst_sample_cnt got=%0d exp=0", sample_cnt); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL mrst_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (synced !== 1'b0) begin failures++; $display("FAIL mrst_synced got=%0b exp=0", synced); end
    cycle(1, 1, 50, 3, 4, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_first_unchecked got=%0b exp=0", out_valid); end
    checks++; if (synced !== 1'b1) begin failures++; $display("FAIL mrst_resync got=%0b exp=1", synced); end
    cycle(1, 1, 51, 4, 7, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_second_ok got=%0b exp=0", out_valid); end
    cycle(1, 1, 60, 0, 0, 0);
    checks++; if (out_data !== {3'b111, 11'd60}) begin failures++; $display("FAIL mrst_all_bits got=%0h exp=%0h", out_data, {3'b111, 11'd60}); end
  endtask

  task automatic test_err_saturation();
    do_reset();
    cycle(1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 262; k++) cycle(1, 1, 1, 5, 5, 1);
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); end
    checks++; if (sample_cnt !== 16'd263) begin failures++; $display("FAIL sat_sample_cnt got=%0d exp=263", sample_cnt); end
  endtask

  task automatic test_random();
    int gi, gc, gn, si, sc, sn, t;
    bit v, rdy, r;
    logic [13:0] exp;
    do_reset();
    gi = 0; gc = 0; gn = 1;
    for (int k = 0; k < 500; k++) begin
      r   = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) begin gi = 0; gc = 0; gn = 1; end
      si = gi; sc = gc; sn = gn;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: si = si ^ int'($urandom_range(1, 2047));
          1: sc = sc ^ int'($urandom_range(1, 2047));
          default: sn = sn ^ int'($urandom_range(1, 2047));
        endcase
      end
      cycle(r, v, si, sc, sn, rdy);
      if (v) begin
        t = (gc + gn) % MOD; gi = (gi + 1) % MOD; gc = gn; gn = t;
      end
      exp = (m_q.size() > 0) ? m_q[0] : '0;
      checks++;
      if (out_valid !== (m_q.size() > 0) || out_data !== exp || sample_cnt !== 16'(m_scnt) ||
          err_cnt !== 8'(m_ecnt) || overflow !== m_ovf || synced !== m_synced) begin
        failures++;
        $display("FAIL random k=%0d got v=%0b d=%0h s=%0d e=%0d o=%0b y=%0b exp v=%0b d=%0h s=%0d e=%0d o=%0b y=%0b",
                 k, out_valid, out_data, sample_cnt, err_cnt, overflow, synced,
                 (m_q.size() > 0), exp, m_scnt, m_ecnt, m_ovf, m_synced);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; i = '0; c = '0; n = '0; out_ready = 1'b0;
    test_reset();
    test_clean_run();
    test_sum_error();
    test_wrap();
    test_overflow();
    test_restart_gaps();
    test_mid_reset();
    test_err_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
